// File: rtl/exu_wb_arbiter_if.sv
// Writeback request channel from one execute unit to the writeback arbiter.
// The source drives the request fields and holds them stable until it sees ready.
interface exu_wb_arbiter_if #(
  parameter int unsigned DW  = 32,
  parameter int unsigned AW  = 5,
  parameter int unsigned IDW = 3
);
  logic           we;
  logic [AW-1:0]  waddr;
  logic [DW-1:0]  wdata;
  logic [IDW-1:0] commit_id;
  logic           ready;

  // Execute unit side
  modport master (
    output we, waddr, wdata, commit_id,
    input  ready
  );

  // Arbiter side
  modport slave (
    input  we, waddr, wdata, commit_id,
    output ready
  );
endinterface

// File: rtl/exu_wb_arbiter.sv
// Writeback arbiter: merges LSU/MDU/ALU/CSR GPR writes onto one regfile write
// port and the commit interface, with a registered one-cycle output stage.
// Base priority lsu > mdu > alu > csr; a requester denied STARVE_LIMIT cycles
// in a row is promoted above non-starved requesters.
// Optional macro WB_ARB_PERF_CNT_EN adds conflict_cnt_o and csr_wait_cnt_o.
module exu_wb_arbiter #(
  parameter int unsigned DW           = 32,
  parameter int unsigned AW           = 5,
  parameter int unsigned IDW          = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  exu_wb_arbiter_if.slave lsu_io,
  exu_wb_arbiter_if.slave mdu_io,
  exu_wb_arbiter_if.slave alu_io,
  exu_wb_arbiter_if.slave csr_io,
  output logic           reg_we_o,
  output logic [AW-1:0]  reg_waddr_o,
  output logic [DW-1:0]  reg_wdata_o,
  output logic           commit_valid_o,
  output logic [IDW-1:0] commit_id_o
`ifdef WB_ARB_PERF_CNT_EN
  ,
  output logic [31:0]    conflict_cnt_o,
  output logic [31:0]    csr_wait_cnt_o
`endif
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LimitC = CW'(STARVE_LIMIT);

  // Source index 0..3 = lsu, mdu, alu, csr (also the base priority order)
  logic [3:0]     req;
  logic [AW-1:0]  waddr_a [4];
  logic [DW-1:0]  wdata_a [4];
  logic [IDW-1:0] id_a    [4];

  assign req        = {csr_io.we, alu_io.we, mdu_io.we, lsu_io.we};
  assign waddr_a[0] = lsu_io.waddr;
  assign waddr_a[1] = mdu_io.waddr;
  assign waddr_a[2] = alu_io.waddr;
  assign waddr_a[3] = csr_io.waddr;
  assign wdata_a[0] = lsu_io.wdata;
  assign wdata_a[1] = mdu_io.wdata;
  assign wdata_a[2] = alu_io.wdata;
  assign wdata_a[3] = csr_io.wdata;
  assign id_a[0]    = lsu_io.commit_id;
  assign id_a[1]    = mdu_io.commit_id;
  assign id_a[2]    = alu_io.commit_id;
  assign id_a[3]    = csr_io.commit_id;

  logic [CW-1:0]  cnt_q [4];
  logic [CW-1:0]  cnt_d [4];
  logic [3:0]     starved;
  logic [3:0]     pool;
  logic [3:0]     gnt;
  logic           found;
  logic           fire;
  logic [AW-1:0]  sel_waddr;
  logic [DW-1:0]  sel_wdata;
  logic [IDW-1:0] sel_id;

  logic           reg_we_q, reg_we_d;
  logic [AW-1:0]  reg_waddr_q, reg_waddr_d;
  logic [DW-1:0]  reg_wdata_q, reg_wdata_d;
  logic           commit_valid_q, commit_valid_d;
  logic [IDW-1:0] commit_id_q, commit_id_d;

  // Grant: starved requesters form the candidate pool if any exist, then fixed priority
  always_comb begin
    starved = '0;
    for (int i = 0; i < 4; i++) begin
      starved[i] = req[i] && (cnt_q[i] == LimitC);
    end
    pool  = (|starved) ? starved : req;
    gnt   = '0;
    found = 1'b0;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (pool[i] && !found) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign lsu_io.ready = gnt[0];
  assign mdu_io.ready = gnt[1];
  assign alu_io.ready = gnt[2];
  assign csr_io.ready = gnt[3];
  assign fire         = |gnt;

  // Winner field mux (gnt is one-hot or zero)
  always_comb begin
    sel_waddr = '0;
    sel_wdata = '0;
    sel_id    = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt[i]) begin
        sel_waddr = waddr_a[i];
        sel_wdata = wdata_a[i];
        sel_id    = id_a[i];
      end
    end
  end

  // Starvation counters: count denied request cycles, clear on grant or idle
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!req[i] || gnt[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != LimitC) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Output stage next state: x0 writes still commit but do not write the regfile
  always_comb begin
    reg_we_d       = fire && (sel_waddr != '0);
    commit_valid_d = fire;
    reg_waddr_d    = fire ? sel_waddr : reg_waddr_q;
    reg_wdata_d    = fire ? sel_wdata : reg_wdata_q;
    commit_id_d    = fire ? sel_id    : commit_id_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_we_q       <= 1'b0;
      reg_waddr_q    <= '0;
      reg_wdata_q    <= '0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      reg_we_q       <= reg_we_d;
      reg_waddr_q    <= reg_waddr_d;
      reg_wdata_q    <= reg_wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_id_q    <= commit_id_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign reg_we_o       = reg_we_q;
  assign reg_waddr_o    = reg_waddr_q;
  assign reg_wdata_o    = reg_wdata_q;
  assign commit_valid_o = commit_valid_q;
  assign commit_id_o    = commit_id_q;

`ifdef WB_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] csr_wait_cnt_q, csr_wait_cnt_d;

  // Perf counters: req & (req - 1) is nonzero iff two or more requests are set
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    csr_wait_cnt_d = csr_wait_cnt_q;
    if ((req & (req - 4'd1)) != 4'd0) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
    if (req[3] && !gnt[3]) begin
      csr_wait_cnt_d = csr_wait_cnt_q + 32'd1;
    end
  end

  // Perf counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= '0;
      csr_wait_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      csr_wait_cnt_q <= csr_wait_cnt_d;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
  assign csr_wait_cnt_o = csr_wait_cnt_q;
`endif

endmodule

// File: tb/tb_exu_wb_arbiter.sv
// Directed self-checking bench for exu_wb_arbiter (default STARVE_LIMIT = 4).
module tb_exu_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        commit_valid;
  logic [2:0]  commit_id;
  logic [3:0]  rdy;
  int          n_cmp = 0;
  int          n_err = 0;
`ifdef WB_ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt;
  logic [31:0] csr_wait_cnt;
`endif

  exu_wb_arbiter_if lsu_if ();
  exu_wb_arbiter_if mdu_if ();
  exu_wb_arbiter_if alu_if ();
  exu_wb_arbiter_if csr_if ();

  exu_wb_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_io         (lsu_if),
    .mdu_io         (mdu_if),
    .alu_io         (alu_if),
    .csr_io         (csr_if),
    .reg_we_o       (reg_we),
    .reg_waddr_o    (reg_waddr),
    .reg_wdata_o    (reg_wdata),
    .commit_valid_o (commit_valid),
    .commit_id_o    (commit_id)
`ifdef WB_ARB_PERF_CNT_EN
    ,
    .conflict_cnt_o (conflict_cnt),
    .csr_wait_cnt_o (csr_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign rdy = {csr_if.ready, alu_if.ready, mdu_if.ready, lsu_if.ready};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic we, input logic [4:0] a,
                       input logic [31:0] d, input logic [2:0] id);
    case (s)
      0: begin lsu_if.we = we; lsu_if.waddr = a; lsu_if.wdata = d; lsu_if.commit_id = id; end
      1: begin mdu_if.we = we; mdu_if.waddr = a; mdu_if.wdata = d; mdu_if.commit_id = id; end
      2: begin alu_if.we = we; alu_if.waddr = a; alu_if.wdata = d; alu_if.commit_id = id; end
      default: begin
        csr_if.we = we; csr_if.waddr = a; csr_if.wdata = d; csr_if.commit_id = id;
      end
    endcase
  endtask

  task automatic idle_all();
    for (int s = 0; s < 4; s++) drive(s, 1'b0, 5'd0, 32'd0, 3'd0);
  endtask

  initial begin
    // Reset with a pending LSU request: no grant while rst is high
    rst = 1'b1;
    idle_all();
    drive(0, 1'b1, 5'd9, 32'h99, 3'd1);
    #1;
    check("rst_ready", {28'd0, rdy}, 32'h0);
    step();
    step();
    check("rst_we", {31'd0, reg_we}, 32'd0);
    check("rst_cv", {31'd0, commit_valid}, 32'd0);
    check("rst_waddr", {27'd0, reg_waddr}, 32'd0);
    check("rst_wdata", reg_wdata, 32'd0);
    check("rst_id", {29'd0, commit_id}, 32'd0);
    idle_all();
    rst = 1'b0;
    step();

    // Single ALU request
    drive(2, 1'b1, 5'd5, 32'h12345678, 3'd2);
    #1;
    check("alu_ready", {28'd0, rdy}, 32'b0100);
    step();
    idle_all();
    check("alu_we", {31'd0, reg_we}, 32'd1);
    check("alu_waddr", {27'd0, reg_waddr}, 32'd5);
    check("alu_wdata", reg_wdata, 32'h12345678);
    check("alu_cv", {31'd0, commit_valid}, 32'd1);
    check("alu_id", {29'd0, commit_id}, 32'd2);
    step();
    check("alu_we_after", {31'd0, reg_we}, 32'd0);
    check("alu_cv_after", {31'd0, commit_valid}, 32'd0);
    check("hold_waddr", {27'd0, reg_waddr}, 32'd5);
    check("hold_wdata", reg_wdata, 32'h12345678);

    // LSU and CSR collide; LSU first, CSR next cycle
    drive(0, 1'b1, 5'd3, 32'hA, 3'd1);
    drive(3, 1'b1, 5'd4, 32'hB, 3'd3);
    #1;
    check("col_ready0", {28'd0, rdy}, 32'b0001);
    step();
    drive(0, 1'b0, 5'd0, 32'd0, 3'd0);
    #1;
    check("col_ready1", {28'd0, rdy}, 32'b1000);
    check("col_waddr1", {27'd0, reg_waddr}, 32'd3);
    check("col_wdata1", reg_wdata, 32'hA);
    step();
    idle_all();
    check("col_waddr2", {27'd0, reg_waddr}, 32'd4);
    check("col_wdata2", reg_wdata, 32'hB);
    check("col_id2", {29'd0, commit_id}, 32'd3);
    check("col_we2", {31'd0, reg_we}, 32'd1);
    step();

    // x0 write commits without writing the regfile
    drive(1, 1'b1, 5'd0, 32'hDEAD, 3'd6);
    step();
    idle_all();
    check("x0_we", {31'd0, reg_we}, 32'd0);
    check("x0_cv", {31'd0, commit_valid}, 32'd1);
    check("x0_id", {29'd0, commit_id}, 32'd6);
    step();

    // Starvation: lsu, mdu, csr request continuously. mdu and csr both saturate
    // after cycle 3; in cycle 4 both are starved and mdu wins on base priority,
    // csr stays saturated and wins alone in cycle 5, lsu wins again in cycle 6.
    drive(0, 1'b1, 5'd1, 32'h11, 3'd0);
    drive(1, 1'b1, 5'd2, 32'h22, 3'd1);
    drive(3, 1'b1, 5'd7, 32'h77, 3'd5);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("stv_lsu_win", {28'd0, rdy}, 32'b0001);
      check("stv_csr_cnt", {29'd0, dut.cnt_q[3]}, c);
      step();
    end
    check("stv_c4_ready", {28'd0, rdy}, 32'b0010);
    check("stv_c4_csr_cnt", {29'd0, dut.cnt_q[3]}, 32'd4);
    step();
    check("stv_c5_ready", {28'd0, rdy}, 32'b1000);
    check("stv_c5_waddr", {27'd0, reg_waddr}, 32'd2);
    step();
    check("stv_c6_ready", {28'd0, rdy}, 32'b0001);
    check("stv_c6_csr_cnt", {29'd0, dut.cnt_q[3]}, 32'd0);
    check("stv_c6_id", {29'd0, commit_id}, 32'd5);
    check("stv_c6_wdata", reg_wdata, 32'h77);
    step();

    // Reset mid-operation with all four requesting
    drive(2, 1'b1, 5'd8, 32'h88, 3'd2);
    rst = 1'b1;
    #1;
    check("mrst_ready", {28'd0, rdy}, 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("mrst_we", {31'd0, reg_we}, 32'd0);
    check("mrst_cv", {31'd0, commit_valid}, 32'd0);
    check("mrst_waddr", {27'd0, reg_waddr}, 32'd0);
    check("mrst_wdata", reg_wdata, 32'd0);
    check("mrst_id", {29'd0, commit_id}, 32'd0);
    check("mrst_csr_cnt", {29'd0, dut.cnt_q[3]}, 32'd0);
    check("mrst_mdu_cnt", {29'd0, dut.cnt_q[1]}, 32'd0);
    check("mrst_first", {28'd0, rdy}, 32'b0001);
    step();
    idle_all();
    step();

`ifdef WB_ARB_PERF_CNT_EN
    // Perf counters: alu+csr for 3 cycles (alu wins each, csr counts 0..2 so
    // never starved), then alu alone for 1 cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("perf_rst_conf", conflict_cnt, 32'd0);
    check("perf_rst_wait", csr_wait_cnt, 32'd0);
    drive(2, 1'b1, 5'd10, 32'hA0, 3'd1);
    drive(3, 1'b1, 5'd11, 32'hB0, 3'd2);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("perf_ready", {28'd0, rdy}, 32'b0100);
      step();
    end
    drive(3, 1'b0, 5'd0, 32'd0, 3'd0);
    step();
    idle_all();
    check("perf_conflict", conflict_cnt, 32'd3);
    check("perf_csr_wait", csr_wait_cnt, 32'd3);
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
